// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle instruction-sequencing controller.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        BRANCH
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] IMM_DP   = 2'b00;
    localparam logic [1:0] IMM_MEM  = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;
    localparam logic [1:0] IMM_NONE = 2'b11;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALUOUT = 2'b10;

    // True on the cycle an instruction leaves its final state.
    function automatic logic retires(input state_t s, input logic mem_ack);
        return (s == ALU_WB) || (s == MEM_WB) || (s == BRANCH) ||
               ((s == MEM_WRITE) && mem_ack);
    endfunction

endpackage

// File: rtl/multicycle_controller_ctrl_next_state.sv
// Combinational next-state logic for the multicycle controller FSM.
module ctrl_next_state
    import multicycle_controller_pkg::*;
(
    input  state_t     state,
    input  logic [1:0] op,
    input  logic       func_imm,
    input  logic       func_ldr,
    input  logic       cond_ex,
    input  logic       mem_ack,
    output state_t     state_next
);

    always_comb begin
        state_next = state;
        case (state)
            FETCH:     if (mem_ack) state_next = DECODE;
            DECODE: begin
                if (!cond_ex || op == OP_UNDEF) state_next = FETCH;
                else if (op == OP_DP)           state_next = func_imm ? EXEC_I : EXEC_R;
                else if (op == OP_MEM)          state_next = MEM_ADR;
                else                            state_next = BRANCH;
            end
            MEM_ADR:   state_next = func_ldr ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ack) state_next = MEM_WB;
            MEM_WB:    state_next = FETCH;
            MEM_WRITE: if (mem_ack) state_next = FETCH;
            EXEC_R:    state_next = ALU_WB;
            EXEC_I:    state_next = ALU_WB;
            ALU_WB:    state_next = FETCH;
            BRANCH:    state_next = FETCH;
            default:   state_next = FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller: state register, retired-instruction counter and
// output decode driven directly from the current state and inputs.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  op,
    input  logic [5:0]  func,
    input  logic        cond_ex,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_w,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic        alu_op,
    output logic [1:0]  result_src,
    output logic        reg_w,
    output logic        busy,
    output logic        illegal,
    output logic [31:0] retired
);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] retired_reg;
    logic        unused_func;

    assign unused_func = ^func[4:1];

    ctrl_next_state u_next_state (
        .state      (state_reg),
        .op         (op),
        .func_imm   (func[5]),
        .func_ldr   (func[0]),
        .cond_ex    (cond_ex),
        .mem_ack    (mem_ack),
        .state_next (state_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retires(state_reg, mem_ack))
                retired_reg <= retired_reg + 32'd1;
        end
    end

    assign retired = retired_reg;

    // Gating on rst_n keeps FETCH's request and write strobes quiet during reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_w      = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_REG;
        imm_src    = IMM_DP;
        reg_src    = 2'b00;
        alu_op     = 1'b0;
        result_src = RES_ALU;
        reg_w      = 1'b0;
        busy       = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            busy = (state_reg != FETCH);
            case (state_reg)
                FETCH: begin
                    mem_req   = 1'b1;
                    ir_write  = mem_ack;
                    pc_write  = mem_ack;
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_FOUR;
                end
                DECODE: begin
                    illegal = (op == OP_UNDEF);
                    case (op)
                        OP_DP:   {imm_src, reg_src} = func[5] ? {IMM_DP, 2'b10} : {IMM_NONE, 2'b00};
                        OP_MEM:  {imm_src, reg_src} = func[0] ? {IMM_MEM, 2'b00} : {IMM_MEM, 2'b10};
                        OP_BR:   {imm_src, reg_src} = {IMM_BR, 2'b11};
                        default: {imm_src, reg_src} = 4'b0000;
                    endcase
                end
                MEM_ADR:   alu_src_b = ALUB_IMM;
                MEM_READ: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                MEM_WB: begin
                    reg_w      = 1'b1;
                    result_src = RES_MEM;
                end
                MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_w   = 1'b1;
                    adr_src = 1'b1;
                end
                EXEC_R:    alu_op = 1'b1;
                EXEC_I: begin
                    alu_src_b = ALUB_IMM;
                    alu_op    = 1'b1;
                end
                ALU_WB: begin
                    reg_w      = 1'b1;
                    result_src = RES_ALUOUT;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    imm_src   = IMM_BR;
                    pc_write  = 1'b1;
                end
                default: busy = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares outputs with hand-derived values.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  op;
    logic [5:0]  func;
    logic        cond_ex;
    logic        mem_ack;
    logic        mem_req, mem_w, adr_src, ir_write, pc_write, alu_src_a;
    logic [1:0]  alu_src_b, imm_src, reg_src, result_src;
    logic        alu_op, reg_w, busy, illegal;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func       (func),
        .cond_ex    (cond_ex),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_w      (mem_w),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .alu_op     (alu_op),
        .result_src (result_src),
        .reg_w      (reg_w),
        .busy       (busy),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, 32'(dut.state_reg), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [5:0] f, input logic c, input logic a);
        op = o; func = f; cond_ex = c; mem_ack = a;
        #1;
    endtask

    // Fetch cycle with mem_ack high; also confirms the count left by the prior instruction.
    task automatic run_fetch(input string tag, input logic [1:0] o, input logic [5:0] f,
                             input logic c, input logic [31:0] exp_retired);
        tick();
        drive(o, f, c, 1'b1);
        check_state({tag, " fetch state"}, FETCH);
        check({tag, " fetch ir_write"}, 32'(ir_write), 32'd1);
        check({tag, " fetch pc_write"}, 32'(pc_write), 32'd1);
        check({tag, " fetch alu_src_b"}, 32'(alu_src_b), 32'd2);
        check({tag, " fetch retired"}, retired, exp_retired);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        op = 2'b00; func = 6'd0; cond_ex = 1'b1; mem_ack = 1'b1;
        #12;
        check_state("reset state", FETCH);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset pc_write", 32'(pc_write), 32'd0);
        check("reset ir_write", 32'(ir_write), 32'd0);
        check("reset retired", retired, 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b00, 6'd0, 1'b1, 1'b0);
        check("fetch wait mem_req", 32'(mem_req), 32'd1);
        check("fetch wait adr_src", 32'(adr_src), 32'd0);
        check("fetch wait ir_write", 32'(ir_write), 32'd0);
        tick();
        check_state("fetch wait hold", FETCH);

        // DP register: FETCH DECODE EXEC_R ALU_WB
        run_fetch("dpr", 2'b00, 6'b000000, 1'b1, 32'd0);
        tick();
        check_state("dpr decode", DECODE);
        check("dpr imm_src", 32'(imm_src), 32'd3);
        check("dpr reg_src", 32'(reg_src), 32'd0);
        check("dpr busy", 32'(busy), 32'd1);
        check("dpr decode mem_req", 32'(mem_req), 32'd0);
        tick();
        check_state("dpr exec", EXEC_R);
        check("dpr alu_src_b", 32'(alu_src_b), 32'd0);
        check("dpr alu_op", 32'(alu_op), 32'd1);
        tick();
        check_state("dpr wb", ALU_WB);
        check("dpr reg_w", 32'(reg_w), 32'd1);
        check("dpr result_src", 32'(result_src), 32'd2);

        // LDR with two wait cycles in MEM_READ: reg_w lands in cycle 7
        run_fetch("ldr", 2'b01, 6'b000001, 1'b1, 32'd1);
        tick();
        drive(2'b01, 6'b000001, 1'b1, 1'b0);
        check("ldr imm_src", 32'(imm_src), 32'd1);
        check("ldr reg_src", 32'(reg_src), 32'd0);
        tick();
        check_state("ldr adr", MEM_ADR);
        check("ldr adr alu_src_b", 32'(alu_src_b), 32'd1);
        check("ldr adr alu_op", 32'(alu_op), 32'd0);
        tick();
        check_state("ldr read wait1", MEM_READ);
        check("ldr read mem_req", 32'(mem_req), 32'd1);
        check("ldr read adr_src", 32'(adr_src), 32'd1);
        tick();
        check_state("ldr read wait2", MEM_READ);
        tick();
        drive(2'b01, 6'b000001, 1'b1, 1'b1);
        check_state("ldr read ack", MEM_READ);
        tick();
        check_state("ldr wb cycle7", MEM_WB);
        check("ldr reg_w", 32'(reg_w), 32'd1);
        check("ldr result_src", 32'(result_src), 32'd1);

        // STR, no waits
        run_fetch("str", 2'b01, 6'b000000, 1'b1, 32'd2);
        tick();
        check("str imm_src", 32'(imm_src), 32'd1);
        check("str reg_src", 32'(reg_src), 32'd2);
        tick();
        check_state("str adr", MEM_ADR);
        tick();
        check_state("str write", MEM_WRITE);
        check("str mem_w", 32'(mem_w), 32'd1);
        check("str mem_req", 32'(mem_req), 32'd1);
        check("str adr_src", 32'(adr_src), 32'd1);

        // Branch taken
        run_fetch("b", 2'b10, 6'd0, 1'b1, 32'd3);
        tick();
        check("b imm_src", 32'(imm_src), 32'd2);
        check("b reg_src", 32'(reg_src), 32'd3);
        tick();
        check_state("b branch", BRANCH);
        check("b pc_write", 32'(pc_write), 32'd1);
        check("b alu_src_a", 32'(alu_src_a), 32'd1);
        check("b alu_src_b", 32'(alu_src_b), 32'd1);
        check("b branch imm_src", 32'(imm_src), 32'd2);

        // Branch with condition failed: back to FETCH, not counted
        run_fetch("bnc", 2'b10, 6'd0, 1'b0, 32'd4);
        tick();
        check_state("bnc decode", DECODE);
        check("bnc decode pc_write", 32'(pc_write), 32'd0);

        // DP immediate
        run_fetch("dpi", 2'b00, 6'b100000, 1'b1, 32'd4);
        tick();
        check("dpi imm_src", 32'(imm_src), 32'd0);
        check("dpi reg_src", 32'(reg_src), 32'd2);
        tick();
        check_state("dpi exec", EXEC_I);
        check("dpi alu_src_b", 32'(alu_src_b), 32'd1);
        check("dpi alu_op", 32'(alu_op), 32'd1);
        tick();
        check_state("dpi wb", ALU_WB);

        // Undefined op
        run_fetch("ill", 2'b11, 6'd0, 1'b1, 32'd5);
        tick();
        check_state("ill decode", DECODE);
        check("ill illegal", 32'(illegal), 32'd1);
        check("ill reg_w", 32'(reg_w), 32'd0);
        check("ill pc_write", 32'(pc_write), 32'd0);

        // Reset during a stalled store
        run_fetch("rst", 2'b01, 6'b000000, 1'b1, 32'd5);
        check("ill illegal cleared", 32'(illegal), 32'd0);
        tick();
        drive(2'b01, 6'b000000, 1'b1, 1'b0);
        tick();
        tick();
        check_state("rst write", MEM_WRITE);
        check("rst mem_w before", 32'(mem_w), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mem_w async", 32'(mem_w), 32'd0);
        check("rst mem_req async", 32'(mem_req), 32'd0);
        check_state("rst state async", FETCH);
        check("rst retired async", retired, 32'd0);
        mem_ack = 1'b1;
        tick();
        check("rst hold pc_write", 32'(pc_write), 32'd0);
        check("rst hold reg_w", 32'(reg_w), 32'd0);
        check("rst hold mem_w", 32'(mem_w), 32'd0);
        rst_n = 1'b1;
        drive(2'b01, 6'b000000, 1'b1, 1'b0);
        check_state("rst released", FETCH);
        check("rst released retired", retired, 32'd0);

        // Counter wrap on a retired store
        force dut.retired_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_reg;
        run_fetch("wrap", 2'b01, 6'b000000, 1'b1, 32'hFFFF_FFFF);
        tick();
        tick();
        tick();
        check_state("wrap write", MEM_WRITE);
        tick();
        drive(2'b00, 6'd0, 1'b1, 1'b0);
        check_state("wrap fetch", FETCH);
        check("wrap retired", retired, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  2  instruction class: 00 DP, 01 MEM, 10 BRANCH, 11 undefined
- func  in  6  function field; func[5] = DP immediate, func[0] = LDR (1) / STR (0)
- cond_ex  in  1  condition check passed for the current instruction
- mem_ack  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_w  out  1  memory write strobe
- adr_src  out  1  0 = PC address, 1 = ALU-result address
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- alu_src_a  out  1  0 = register, 1 = PC
- alu_src_b  out  2  00 register, 01 immediate, 10 constant 4
- imm_src  out  2  00 DP-immediate, 01 memory offset, 10 branch offset, 11 unused
- reg_src  out  2  register-read source select
- alu_op  out  1  ALU decodes func when 1; add when 0
- result_src  out  2  00 ALU result, 01 memory data, 10 ALU out direct
- reg_w  out  1  register-file write
- busy  out  1  high when not in FETCH
- illegal  out  1  one-cycle pulse on undefined op
- retired  out  32  instructions-completed counter

Function
REQ-003 The FSM SHALL use the states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB and BRANCH.
REQ-004 FETCH SHALL assert mem_req with adr_src=0, hold while mem_ack=0, and on mem_ack=1 pulse ir_write and pc_write (alu_src_a=1, alu_src_b=10), then go to DECODE.
REQ-005 DECODE SHALL go to FETCH if cond_ex=0 or op=11 (pulse illegal for op=11); otherwise op=00 SHALL go to EXEC_I if func[5]=1, else EXEC_R; op=01 SHALL go to MEM_ADR; op=10 SHALL go to BRANCH.
REQ-006 In DECODE, imm_src/reg_src SHALL be: DP-reg 11/00, DP-imm 00/10, STR 01/10, LDR 01/00, B 10/11.
REQ-007 EXEC_R SHALL drive alu_src_b=00 and alu_op=1; EXEC_I SHALL drive alu_src_b=01 and alu_op=1; both SHALL go to ALU_WB.
REQ-008 ALU_WB SHALL assert reg_w with result_src=10 and then go to FETCH.
REQ-009 MEM_ADR SHALL drive alu_src_b=01 and alu_op=0, then go to MEM_READ if func[0]=1, else to MEM_WRITE.
REQ-010 MEM_READ SHALL assert mem_req with adr_src=1 and hold until mem_ack, then go to MEM_WB.
REQ-011 MEM_WB SHALL assert reg_w with result_src=01, then go to FETCH.
REQ-012 MEM_WRITE SHALL assert mem_req and mem_w with adr_src=1, hold until mem_ack, then go to FETCH.
REQ-013 BRANCH SHALL drive alu_src_a=1, alu_src_b=01 and imm_src=10, assert pc_write, then go to FETCH.
REQ-014 All outputs not named for a state SHALL be 0 in that state; outputs SHALL be decoded from state and inputs only, with no register stage.
REQ-015 Latency SHALL be, with mem_ack tied high: B 3 cycles, DP 4, STR 4, LDR 5; each wait cycle with mem_ack=0 SHALL add 1 cycle.
REQ-016 retired SHALL increment by 1 when leaving ALU_WB, MEM_WB, BRANCH, or MEM_WRITE on mem_ack, and SHALL wrap from 0xFFFFFFFF to 0; condition-failed and illegal instructions SHALL not count.
REQ-017 mem_ack outside FETCH, MEM_READ and MEM_WRITE SHALL be ignored.

Reset
REQ-018 While rst_n=0, the state SHALL be FETCH, retired SHALL be 0, illegal SHALL be 0, and every other output SHALL be 0 except mem_req, which follows FETCH only after rst_n is released.
REQ-019 Reset asserted mid-access SHALL abandon the access immediately, and no pc_write, reg_w or mem_w SHALL occur.

Structure
REQ-020 A shared package SHALL hold the state enum, op codes (OP_DP, OP_MEM, OP_BR), and the imm_src, alu_src_b and result_src encodings.
REQ-021 The block SHALL contain one sub-module, ctrl_next_state, which is combinational next-state logic; the output decode and the counter SHALL stay in the top level.

Verification
REQ-022 With DP-reg (op=00, func=000000), cond_ex=1 and mem_ack=1, states SHALL be FETCH-DECODE-EXEC_R-ALU_WB, with reg_w=1 in cycle 4 and retired=1.
REQ-023 With LDR (op=01, func[0]=1) and mem_ack low for 2 cycles in MEM_READ, reg_w SHALL assert in cycle 7 with result_src=01.
REQ-024 With B (op=10) and cond_ex=0, the FSM SHALL return to FETCH after DECODE, pc_write SHALL occur only in FETCH, and retired SHALL be unchanged.
REQ-025 With op=11, illegal SHALL pulse for 1 cycle in DECODE, the next state SHALL be FETCH, and no write SHALL occur.
REQ-026 With rst_n dropped during MEM_WRITE while mem_ack=0, mem_w SHALL go to 0 asynchronously, and after release the FSM SHALL be in FETCH with retired=0.
REQ-027 With retired preloaded to 0xFFFFFFFF via force and one STR retired, retired SHALL be 0.
